store_drain_arbiter: RTL and testbench

// - Drains retired (committed) stores from the store-queue head into the single D-cache request port.
// - Shares that port with speculative load requests from the LSU.
// - Tracks how many SQ-head entries are committed, using the per-cycle store-commit count from retire.
// - Arbitrates load vs. store with an urgency threshold and an anti-starvation counter.
// - After a halt retires, blocks loads, empties all committed stores, then raises drain_done.

---
 rtl/store_drain_arbiter_pkg.sv | 14 +
 rtl/store_drain_arbiter_dc_req_skid.sv | 17 +
 rtl/store_drain_arbiter.sv | 81 ++++++++
 tb/tb_store_drain_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/store_drain_arbiter_pkg.sv
// store_drain_arbiter_pkg: shared request, address and drain-state types for the store drain arbiter.
package store_drain_arbiter_pkg;
  typedef logic [31:0] ADDR;
  typedef logic [31:0] DATA;
  typedef logic [1:0]  MEM_SIZE;
  typedef struct packed {
    logic    valid;
    logic    is_store;
    ADDR     addr;
    DATA     data;
    MEM_SIZE size;
  } DC_REQ;
  typedef enum logic [1:0] {RUN, HALT_DRAIN, DONE} DRAIN_STATE;
endpackage

// File: rtl/store_drain_arbiter_dc_req_skid.sv
// dc_req_skid: single-entry valid/ready holding register for the D-cache request port.
module dc_req_skid
  import store_drain_arbiter_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  ready,
  input  DC_REQ d,
  output logic  cap,
  output DC_REQ q
);
  // No captures while reset is held, so no grant can leak out during reset.
  assign cap = reset && (!q.valid || ready);
  always_ff @(posedge clock or negedge reset)
    if (!reset) q <= '0;
    else if (cap) q <= d;
endmodule

// File: rtl/store_drain_arbiter.sv
// store_drain_arbiter: drains committed stores into the D-cache port, sharing it with loads,
// with urgency/anti-starvation priority and a halt drain sequence.
module store_drain_arbiter
  import store_drain_arbiter_pkg::*;
#(
  parameter int N             = 2,
  parameter int SQ_DEPTH      = 8,
  parameter int URGENT_THRESH = 6,
  parameter int STARVE_LIMIT  = 4,
  localparam int CW = $clog2(N + 1),
  localparam int PW = $clog2(SQ_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW-1:0] commit_store_count,
  input  logic          halt_retired,
  input  logic          sq_head_valid,
  input  ADDR           sq_head_addr,
  input  DATA           sq_head_data,
  input  MEM_SIZE       sq_head_size,
  output logic          sq_pop,
  input  logic          ld_req_valid,
  input  ADDR           ld_req_addr,
  input  MEM_SIZE       ld_req_size,
  output logic          ld_req_ready,
  output logic          dc_req_valid,
  output logic          dc_req_is_store,
  output ADDR           dc_req_addr,
  output DATA           dc_req_data,
  output MEM_SIZE       dc_req_size,
  input  logic          dc_req_ready,
  output logic [PW-1:0] pending_count,
  output logic          drain_done,
  output logic          overflow_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int XW = PW + CW;
  logic cap, store_elig, force_st, st_gnt, ld_gnt;
  logic [SW-1:0] starve, starve_next;
  logic [XW-1:0] sum;
  DRAIN_STATE state, state_next;
  DC_REQ req, q;
  dc_req_skid u_skid (.clock(clock), .reset(reset), .ready(dc_req_ready), .d(req), .cap(cap), .q(q));
  always_comb begin
    store_elig  = pending_count != '0 && sq_head_valid;
    force_st    = state != RUN || pending_count >= PW'(URGENT_THRESH) || starve == SW'(STARVE_LIMIT);
    st_gnt      = cap && state != DONE && store_elig && (force_st || !ld_req_valid);
    ld_gnt      = cap && !st_gnt && ld_req_valid && state == RUN;
    req.valid    = st_gnt || ld_gnt;
    req.is_store = st_gnt;
    req.addr     = st_gnt ? sq_head_addr : ld_req_addr;
    req.data     = st_gnt ? sq_head_data : '0;
    req.size     = st_gnt ? sq_head_size : ld_req_size;
    // A store grant implies pending_count>0, so this never underflows.
    sum         = XW'(pending_count) + XW'(commit_store_count) - XW'(st_gnt);
    starve_next = st_gnt ? '0 :
                  (store_elig && ld_gnt && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
    state_next  = (state == RUN && halt_retired) ? HALT_DRAIN :
                  (state == HALT_DRAIN && pending_count == '0 && cap) ? DONE : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state         <= RUN;
      pending_count <= '0;
      starve        <= '0;
      overflow_err  <= 1'b0;
    end else begin
      state         <= state_next;
      pending_count <= sum > XW'(SQ_DEPTH) ? PW'(SQ_DEPTH) : PW'(sum);
      starve        <= starve_next;
      if (sum > XW'(SQ_DEPTH)) overflow_err <= 1'b1;
    end
  assign sq_pop          = st_gnt;
  assign ld_req_ready    = ld_gnt;
  assign drain_done      = state == DONE;
  assign dc_req_valid    = q.valid;
  assign dc_req_is_store = q.is_store;
  assign dc_req_addr     = q.addr;
  assign dc_req_data     = q.data;
  assign dc_req_size     = q.size;
endmodule

// File: tb/tb_store_drain_arbiter.sv
// tb_store_drain_arbiter: directed scenarios; expected D-cache requests are queued at grant time
// and a separate monitor checks them as the port handshakes.
module tb_store_drain_arbiter;
  import store_drain_arbiter_pkg::*;
  logic clock = 0, reset = 0;
  logic [1:0] commit_store_count = 0;
  logic halt_retired = 0, sq_head_valid = 0, ld_req_valid = 0, dc_req_ready = 1;
  ADDR sq_head_addr = 0, ld_req_addr = 0;
  DATA sq_head_data = 0;
  MEM_SIZE sq_head_size = 2'd2, ld_req_size = 2'd3;
  logic sq_pop, ld_req_ready, dc_req_valid, dc_req_is_store, drain_done, overflow_err;
  ADDR dc_req_addr;
  DATA dc_req_data;
  MEM_SIZE dc_req_size;
  logic [3:0] pending_count;
  int checks = 0, errors = 0;
  DC_REQ exq[$];

  store_drain_arbiter dut (
    .clock(clock), .reset(reset), .commit_store_count(commit_store_count), .halt_retired(halt_retired),
    .sq_head_valid(sq_head_valid), .sq_head_addr(sq_head_addr), .sq_head_data(sq_head_data),
    .sq_head_size(sq_head_size), .sq_pop(sq_pop), .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr),
    .ld_req_size(ld_req_size), .ld_req_ready(ld_req_ready), .dc_req_valid(dc_req_valid),
    .dc_req_is_store(dc_req_is_store), .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
    .dc_req_size(dc_req_size), .dc_req_ready(dc_req_ready), .pending_count(pending_count),
    .drain_done(drain_done), .overflow_err(overflow_err));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Check grant strobes and pending for the current cycle; queue the request a grant must produce.
  task automatic cycle(input bit ep, input bit el, input int pend);
    DC_REQ e;
    @(negedge clock);
    chk("sq_pop", sq_pop, 64'(ep));
    chk("ld_req_ready", ld_req_ready, 64'(el));
    chk("pending_count", pending_count, 64'(pend));
    if (ep) begin
      e = '{valid: 1'b1, is_store: 1'b1, addr: sq_head_addr, data: sq_head_data, size: sq_head_size};
      exq.push_back(e);
    end
    if (el) begin
      e = '{valid: 1'b1, is_store: 1'b0, addr: ld_req_addr, data: '0, size: ld_req_size};
      exq.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    chk("rst_dc_req_valid", dc_req_valid, 0);
    chk("rst_pending", pending_count, 0);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_sq_pop", sq_pop, 0);
    chk("rst_ld_req_ready", ld_req_ready, 0);
    exq.delete();
    commit_store_count = 0; halt_retired = 0; sq_head_valid = 0; ld_req_valid = 0; dc_req_ready = 1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1;
  endtask

  always @(negedge clock)
    if (reset && dc_req_valid && dc_req_ready) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dc_req_unexpected: got addr %0h with nothing expected at %0t", dc_req_addr, $time);
      end else begin
        DC_REQ e;
        e = exq.pop_front();
        chk("dc_req_is_store", dc_req_is_store, 64'(e.is_store));
        chk("dc_req_addr", dc_req_addr, 64'(e.addr));
        chk("dc_req_data", dc_req_data, 64'(e.data));
        chk("dc_req_size", dc_req_size, 64'(e.size));
      end
    end

  initial begin
    do_reset();
    // Store only: two commits drain on consecutive cycles
    commit_store_count = 2; sq_head_valid = 1; sq_head_addr = 32'h100; sq_head_data = 32'hAAAA0000;
    cycle(0, 0, 0);
    commit_store_count = 0;
    cycle(1, 0, 2);
    sq_head_addr = 32'h104; sq_head_data = 32'hBBBB0000;
    cycle(1, 0, 1);
    sq_head_valid = 0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    // Starvation: four load wins, then a forced store, then the counter is back at zero
    commit_store_count = 1;
    cycle(0, 0, 0);
    commit_store_count = 0; ld_req_valid = 1; ld_req_addr = 32'h200; sq_head_valid = 1;
    sq_head_addr = 32'h108; sq_head_data = 32'hCCCC0000;
    for (int i = 0; i < 4; i++) begin
      ld_req_addr = 32'h200 + 32'(i * 4);
      cycle(0, 1, 1);
    end
    cycle(1, 0, 1);
    commit_store_count = 1; ld_req_addr = 32'h220;
    cycle(0, 1, 0);
    commit_store_count = 0; ld_req_addr = 32'h224;
    cycle(0, 1, 1);
    ld_req_valid = 0;
    cycle(1, 0, 1);
    // Urgency: pending climbs to 6 while loads are present
    commit_store_count = 2; ld_req_valid = 1; ld_req_addr = 32'h230; sq_head_addr = 32'h110;
    sq_head_data = 32'hDDDD0000;
    cycle(0, 1, 0);
    cycle(0, 1, 2);
    cycle(0, 1, 4);
    cycle(1, 0, 6);
    commit_store_count = 0;
    cycle(1, 0, 7);
    cycle(1, 0, 6);
    cycle(0, 1, 5);
    ld_req_valid = 0;
    for (int p = 5; p >= 1; p--) cycle(1, 0, p);
    // Backpressure: held store stays stable, commits still count
    commit_store_count = 2; sq_head_addr = 32'h300; sq_head_data = 32'hEEEE0000;
    cycle(0, 0, 0);
    commit_store_count = 0;
    cycle(1, 0, 2);
    dc_req_ready = 0; sq_head_addr = 32'h304; ld_req_valid = 1; commit_store_count = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, i == 0 ? 1 : 2);
      commit_store_count = 0;
      chk("bp_valid", dc_req_valid, 1);
      chk("bp_addr", dc_req_addr, 32'h300);
      chk("bp_data", dc_req_data, 32'hEEEE0000);
    end
    // Reset while stalled
    do_reset();
    // Halt drain with three committed stores
    commit_store_count = 2;
    cycle(0, 0, 0);
    commit_store_count = 1;
    cycle(0, 0, 2);
    commit_store_count = 0; halt_retired = 1;
    cycle(0, 0, 3);
    halt_retired = 0; ld_req_valid = 1; ld_req_addr = 32'h500; sq_head_valid = 1;
    sq_head_addr = 32'h400; sq_head_data = 32'h11110000;
    cycle(1, 0, 3);
    sq_head_addr = 32'h404; sq_head_data = 32'h22220000;
    cycle(1, 0, 2);
    sq_head_addr = 32'h408; sq_head_data = 32'h33330000;
    cycle(1, 0, 1);
    chk("drain_done_early", drain_done, 0);
    cycle(0, 0, 0);
    chk("drain_done_rise", drain_done, 1);
    cycle(0, 0, 0);
    chk("drain_done_sticky", drain_done, 1);
    do_reset();
    // Overflow: pending clamps at 8
    commit_store_count = 2;
    for (int p = 0; p <= 8; p += 2) cycle(0, 0, p);
    chk("overflow_set", overflow_err, 1);
    commit_store_count = 0;
    cycle(0, 0, 8);
    chk("overflow_sticky", overflow_err, 1);
    chk("expected_queue_empty", 64'(exq.size()), 0);
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
